mux_dig: RTL and testbench



---
 rtl/mux_dig_pkg.sv | 13 +
 rtl/mux_dig_sat_cnt.sv | 32 +++
 rtl/mux_dig.sv | 83 ++++++++
 tb/tb_mux_dig.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/mux_dig_pkg.sv
// Shared types and defaults for the mux_dig 4:1 single-bit multiplexer.
package mux_dig_pkg;

    typedef logic [1:0] sel_t;

    localparam sel_t SEL_D0 = 2'b00;
    localparam sel_t SEL_D1 = 2'b01;
    localparam sel_t SEL_D2 = 2'b10;
    localparam sel_t SEL_D3 = 2'b11;

    localparam int CNT_W_DEF = 8;

endpackage

// File: rtl/mux_dig_sat_cnt.sv
// Saturating up-counter with enable and asynchronous active-low clear.
module mux_dig_sat_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    // Hold at all-ones instead of wrapping back to zero.
    always_comb begin
        cnt_d = cnt_q;
        if (en && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/mux_dig.sv
// Single-bit 4:1 mux with registered copy, select-change strobe and optional
// per-select usage counters (built only when MUX_DIG_SEL_CNT_EN is defined).
module mux_dig
    import mux_dig_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s1,
    input  logic             s0,
    input  logic             d0,
    input  logic             d1,
    input  logic             d2,
    input  logic             d3,
    output logic             y,
    output logic             y_q,
    output logic             sel_chg,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1,
    output logic [CNT_W-1:0] cnt2,
    output logic [CNT_W-1:0] cnt3
);

    sel_t       sel;
    logic [3:0] d_vec;

    assign sel   = {s1, s0};
    assign d_vec = {d3, d2, d1, d0};
    // Indexing lets an unknown select propagate X rather than default to d0.
    assign y     = d_vec[sel];

    logic y_d, y_q_r;
    sel_t sel_d, sel_q;
    logic sel_chg_d, sel_chg_q;

    always_comb begin
        y_d       = y;
        sel_d     = sel;
        sel_chg_d = (sel != sel_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q_r     <= 1'b0;
            sel_q     <= SEL_D0;
            sel_chg_q <= 1'b0;
        end else begin
            y_q_r     <= y_d;
            sel_q     <= sel_d;
            sel_chg_q <= sel_chg_d;
        end
    end

    assign y_q     = y_q_r;
    assign sel_chg = sel_chg_q;

`ifdef MUX_DIG_SEL_CNT_EN
    logic [CNT_W-1:0] cnt_arr [4];

    for (genvar i = 0; i < 4; i++) begin : g_cnt
        mux_dig_sat_cnt #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (sel == sel_t'(i)),
            .cnt   (cnt_arr[i])
        );
    end

    assign cnt0 = cnt_arr[0];
    assign cnt1 = cnt_arr[1];
    assign cnt2 = cnt_arr[2];
    assign cnt3 = cnt_arr[3];
`else
    assign cnt0 = '0;
    assign cnt1 = '0;
    assign cnt2 = '0;
    assign cnt3 = '0;
`endif

endmodule

// File: tb/tb_mux_dig.sv
// Bench for mux_dig: directed select table, reset, registered path and a
// randomized run compared against a behavioural model.
module tb_mux_dig;

    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst_n;
    logic             s1, s0;
    logic             d0, d1, d2, d3;
    logic             y, y_q, sel_chg;
    logic [CNT_W-1:0] cnt0, cnt1, cnt2, cnt3;

    int checks;
    int errors;

    // Behavioural reference state
    logic exp_yq;
    logic exp_chg;
    int   prev_sel;
    int   exp_cnt [4];

    mux_dig #(
        .CNT_W (CNT_W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s1      (s1),
        .s0      (s0),
        .d0      (d0),
        .d1      (d1),
        .d2      (d2),
        .d3      (d3),
        .y       (y),
        .y_q     (y_q),
        .sel_chg (sel_chg),
        .cnt0    (cnt0),
        .cnt1    (cnt1),
        .cnt2    (cnt2),
        .cnt3    (cnt3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int cur_sel();
        return (s1 ? 2 : 0) + (s0 ? 1 : 0);
    endfunction

    function automatic logic ref_y();
        logic d_arr [4];
        d_arr[0] = d0;
        d_arr[1] = d1;
        d_arr[2] = d2;
        d_arr[3] = d3;
        return d_arr[cur_sel()];
    endfunction

    task automatic model_reset();
        exp_yq   = 1'b0;
        exp_chg  = 1'b0;
        prev_sel = 0;
        for (int i = 0; i < 4; i++) exp_cnt[i] = 0;
    endtask

    task automatic set_d(input logic [3:0] v);
        d0 = v[0];
        d1 = v[1];
        d2 = v[2];
        d3 = v[3];
    endtask

    task automatic check_regs(input string tag);
        chk({tag, ".y_q"},    32'(y_q),     32'(exp_yq));
        chk({tag, ".sel_chg"}, 32'(sel_chg), 32'(exp_chg));
        chk({tag, ".cnt0"},   32'(cnt0),    32'(exp_cnt[0]));
        chk({tag, ".cnt1"},   32'(cnt1),    32'(exp_cnt[1]));
        chk({tag, ".cnt2"},   32'(cnt2),    32'(exp_cnt[2]));
        chk({tag, ".cnt3"},   32'(cnt3),    32'(exp_cnt[3]));
    endtask

    // Advance one clock edge; the model samples the inputs as the edge sees them.
    task automatic step(input string tag, input bit full);
        int s;
        s        = cur_sel();
        exp_chg  = (s != prev_sel);
        prev_sel = s;
        exp_yq   = ref_y();
`ifdef MUX_DIG_SEL_CNT_EN
        if (exp_cnt[s] < CNT_MAX) exp_cnt[s] = exp_cnt[s] + 1;
`endif
        @(posedge clk);
        #1;
        if (full) check_regs(tag);
        else      chk({tag, ".y_q"}, 32'(y_q), 32'(exp_yq));
    endtask

    logic [1:0] tv_s [8];
    logic [3:0] tv_d [8];
    logic       tv_y [8];
    int         chg_cnt;
    logic [3:0] r;

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        {s1, s0} = 2'b00;
        set_d(4'b0000);
        model_reset();
        #1;
        check_regs("reset0");

        // Table patterns: d written as d0..d3 left to right
        tv_s[0] = 2'b00; tv_d[0] = 4'b1000; tv_y[0] = 1'b1;
        tv_s[1] = 2'b00; tv_d[1] = 4'b0111; tv_y[1] = 1'b0;
        tv_s[2] = 2'b01; tv_d[2] = 4'b0100; tv_y[2] = 1'b1;
        tv_s[3] = 2'b01; tv_d[3] = 4'b1011; tv_y[3] = 1'b0;
        tv_s[4] = 2'b10; tv_d[4] = 4'b0010; tv_y[4] = 1'b1;
        tv_s[5] = 2'b10; tv_d[5] = 4'b1101; tv_y[5] = 1'b0;
        tv_s[6] = 2'b11; tv_d[6] = 4'b0001; tv_y[6] = 1'b1;
        tv_s[7] = 2'b11; tv_d[7] = 4'b1110; tv_y[7] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            {s1, s0} = tv_s[i];
            {d0, d1, d2, d3} = tv_d[i];
            #1;
            chk($sformatf("table%0d.y", i), 32'(y), 32'(tv_y[i]));
        end
        chk("table.y_q_in_reset", 32'(y_q), 32'(0));

        // Release between edges with sel=01: first edge sees a change from 00
        @(negedge clk);
        {s1, s0} = 2'b01;
        set_d(4'b0010);
        rst_n = 1'b1;
        step("post_rst", 1'b1);
        chk("post_rst.chg_hi", 32'(sel_chg), 32'(1));

        // Hold 01 for 3 cycles then 11: exactly one strobe after the change
        for (int i = 0; i < 3; i++) step("hold01", 1'b1);
        chk("hold01.chg_lo", 32'(sel_chg), 32'(0));
        {s1, s0} = 2'b11;
        chg_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            step("to11", 1'b1);
            if (sel_chg) chg_cnt++;
        end
        chk("to11.pulse_count", 32'(chg_cnt), 32'(1));

        // Registered path: y rises immediately, y_q on the following edge
        {s1, s0} = 2'b10;
        set_d(4'b0000);
        step("regpath0", 1'b1);
        d2 = 1'b1;
        #1;
        chk("regpath.y_now", 32'(y), 32'(1));
        chk("regpath.y_q_before", 32'(y_q), 32'(0));
        step("regpath1", 1'b1);
        chk("regpath.y_q_after", 32'(y_q), 32'(1));

        // Select toggling every cycle keeps the strobe high
        for (int i = 0; i < 6; i++) begin
            {s1, s0} = (i % 2 == 0) ? 2'b01 : 2'b10;
            step("toggle", 1'b1);
            chk("toggle.chg_hi", 32'(sel_chg), 32'(1));
        end

        // Randomized run against the model
        for (int i = 0; i < 300; i++) begin
            {s1, s0} = 2'($urandom_range(0, 3));
            r = 4'($urandom_range(0, 15));
            set_d(r);
            #1;
            chk("rand.y", 32'(y), 32'(ref_y()));
            step("rand", 1'b1);
        end

        // Reset mid-cycle clears at once; y keeps following inputs
        rst_n = 1'b0;
        model_reset();
        #1;
        check_regs("midrst");
        {s1, s0} = 2'b11;
        set_d(4'b1000);
        #1;
        chk("midrst.y_follow", 32'(y), 32'(1));
        @(negedge clk);
        rst_n = 1'b1;

        // Saturation: hold 11 for 300 cycles
        for (int i = 0; i < 300; i++) step("sat", (i % 50 == 49));
        check_regs("sat_end");
`ifdef MUX_DIG_SEL_CNT_EN
        chk("sat.cnt3_max", 32'(cnt3), 32'(CNT_MAX));
`else
        chk("sat.cnt3_zero", 32'(cnt3), 32'(0));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
